div_sequencer: RTL and testbench

Multi-cycle controller and iterative datapath for the RV32M divide/remainder ops (DIV, DIVU, REM, REMU) in the EX stage. It accepts one operation from EX and requests a pipeline stall while it runs a radix-2 restoring divide, one iteration per cycle. It then presents a one-cycle result strobe. Divide-by-zero and signed overflow finish on a fast path.

---
 rtl/div_sequencer_pkg.sv | 25 ++
 rtl/div_step.sv | 27 ++
 rtl/div_sequencer.sv | 156 +++++++++++++++
 tb/tb_div_sequencer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_sequencer_pkg.sv
// Shared constants and types for the RV32M divide sequencer.
// Op and state encodings are common to the FSM and its users.
package div_sequencer_pkg;

    localparam int DIV_XLEN  = 32;
    localparam int DIV_CNT_W = 6;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [1:0] {
        DIV_ST_IDLE = 2'd0,
        DIV_ST_CALC = 2'd1,
        DIV_ST_FIN  = 2'd2
    } div_state_e;

    function automatic logic div_is_signed(input logic [1:0] op);
        return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
    endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring divide iteration, purely combinational.
// The shifted partial remainder is one bit wider than XLEN.
module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem,
    input  logic [XLEN-1:0] quot,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic [XLEN-1:0] quot_next
);

    logic [XLEN:0] rem_sh;
    logic [XLEN:0] trial;
    logic          fits;

    // Shift {rem,quot} left, trial-subtract, keep result if no borrow.
    // rem < divisor on entry, so trial[XLEN] is exactly the borrow.
    always_comb begin
        rem_sh    = {rem, quot[XLEN-1]};
        trial     = rem_sh - {1'b0, divisor};
        fits      = ~trial[XLEN];
        rem_next  = fits ? trial[XLEN-1:0] : rem_sh[XLEN-1:0];
        quot_next = {quot[XLEN-2:0], fits};
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU unit for the EX stage.
// Stalls the pipe while iterating; fast path for /0 and overflow.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int XLEN  = DIV_XLEN,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [1:0]      div_op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e state, state_nxt;

    logic [1:0]      op_q;
    logic            neg_q;
    logic            neg_r;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic [XLEN-1:0] dvsr_q;
    logic [XLEN-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;

    logic [XLEN-1:0] rem_nxt;
    logic [XLEN-1:0] quot_nxt;

    logic            s_op;
    logic            s1;
    logic            s2;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic            div_zero;
    logic            ovf;
    logic            accept;
    logic            last;
    logic [XLEN-1:0] fin_val;

    div_step #(.XLEN(XLEN)) u_step (
        .rem       (rem_q),
        .quot      (quot_q),
        .divisor   (dvsr_q),
        .rem_next  (rem_nxt),
        .quot_next (quot_nxt)
    );

    // Operand conditioning and special-case detection at issue.
    always_comb begin
        s_op     = div_is_signed(div_op);
        s1       = s_op & rs1[XLEN-1];
        s2       = s_op & rs2[XLEN-1];
        abs1     = s1 ? -rs1 : rs1;
        abs2     = s2 ? -rs2 : rs2;
        div_zero = (rs2 == '0);
        ovf      = s_op & (rs1 == MIN_NEG) & (&rs2);
        accept   = (state == DIV_ST_IDLE) & start & ~flush;
        last     = (cnt_q == CNT_W'(XLEN-1));
    end

    // Select quotient or remainder and apply the sign fix-up.
    always_comb begin
        fin_val = quot_q;
        unique case (op_q)
            DIV_OP_DIV, DIV_OP_DIVU: fin_val = neg_q ? -quot_q : quot_q;
            DIV_OP_REM, DIV_OP_REMU: fin_val = neg_r ? -rem_q : rem_q;
            default:                 fin_val = quot_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= DIV_ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; flush overrides everything.
    always_comb begin
        state_nxt = state;
        unique case (state)
            DIV_ST_IDLE: begin
                if (accept)
                    state_nxt = (div_zero | ovf) ? DIV_ST_FIN : DIV_ST_CALC;
            end
            DIV_ST_CALC: if (last) state_nxt = DIV_ST_FIN;
            DIV_ST_FIN:  state_nxt = DIV_ST_IDLE;
            default:     state_nxt = DIV_ST_IDLE;
        endcase
        if (flush) state_nxt = DIV_ST_IDLE;
    end

    // Datapath: latch on issue, iterate in CALC, capture result in FIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            res_q  <= '0;
            cnt_q  <= '0;
        end else begin
            unique case (state)
                DIV_ST_IDLE: begin
                    if (accept) begin
                        op_q   <= div_op;
                        dvsr_q <= abs2;
                        cnt_q  <= '0;
                        if (div_zero) begin
                            quot_q <= '1;
                            rem_q  <= rs1;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                        end else if (ovf) begin
                            quot_q <= MIN_NEG;
                            rem_q  <= '0;
                            neg_q  <= 1'b0;
                            neg_r  <= 1'b0;
                        end else begin
                            quot_q <= abs1;
                            rem_q  <= '0;
                            neg_q  <= s1 ^ s2;
                            neg_r  <= s1;
                        end
                    end
                end
                DIV_ST_CALC: begin
                    rem_q  <= rem_nxt;
                    quot_q <= quot_nxt;
                    cnt_q  <= cnt_q + 1'b1;
                end
                DIV_ST_FIN: res_q <= fin_val;
                default: ;
            endcase
        end
    end

    // Outputs: result is live in FIN and held afterwards.
    always_comb begin
        busy      = (state != DIV_ST_IDLE);
        done      = (state == DIV_ST_FIN);
        stall_req = accept | (state == DIV_ST_CALC);
        result    = done ? fin_val : res_q;
    end

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer.
// Table of directed ops plus hand sequences for flush/reset corners.
module tb_div_sequencer;
    import div_sequencer_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   div_op = 2'd0;
    logic [W-1:0] rs1 = '0;
    logic [W-1:0] rs2 = '0;
    logic         stall_req;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    int           n_tests = 0;
    int           n_fail = 0;
    logic [W-1:0] last_res = '0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    always #5 clk = ~clk;

    div_sequencer #(.XLEN(W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .div_op    (div_op),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall_req (stall_req),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    task automatic chk(input string nm, input int id,
                       input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, id, act, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input int idx);
        vec_t         v;
        int           done_cyc;
        int           n_done;
        int           bad_stall;
        int           bad_busy;
        logic [W-1:0] got;
        logic [W-1:0] held;
        v         = vecs[idx];
        done_cyc  = -1;
        n_done    = 0;
        bad_stall = 0;
        bad_busy  = 0;
        got       = '0;
        held      = '0;
        start  = 1'b1;
        div_op = v.op;
        rs1    = v.a;
        rs2    = v.b;
        #3;
        chk("stall_c0", idx, W'(stall_req), W'(1));
        chk("busy_c0", idx, W'(busy), W'(0));
        cyc();
        start = 1'b0;
        for (int c = 1; c <= v.lat + 3; c++) begin
            #3;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = result;
                end
            end
            if (stall_req !== (c < v.lat)) bad_stall++;
            if (busy !== (c <= v.lat)) bad_busy++;
            if (c == v.lat + 2) held = result;
            cyc();
        end
        chk("done_cycle", idx, W'(done_cyc), W'(v.lat));
        chk("done_count", idx, W'(n_done), W'(1));
        chk("result", idx, got, v.res);
        chk("result_held", idx, held, v.res);
        chk("stall_pattern", idx, W'(bad_stall), W'(0));
        chk("busy_pattern", idx, W'(bad_busy), W'(0));
        last_res = v.res;
    endtask

    initial begin : main
        int           n_done;
        int           done_cyc;
        int           bad;
        logic [W-1:0] got;

        vecs[0]  = '{DIV_OP_DIVU, 32'd100, 32'd7, 32'd14, 33};
        vecs[1]  = '{DIV_OP_REMU, 32'd100, 32'd7, 32'd2, 33};
        vecs[2]  = '{DIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33};
        vecs[3]  = '{DIV_OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33};
        vecs[4]  = '{DIV_OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1};
        vecs[5]  = '{DIV_OP_REM, 32'd5, 32'd0, 32'd5, 1};
        vecs[6]  = '{DIV_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 1};
        vecs[7]  = '{DIV_OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1};
        vecs[8]  = '{DIV_OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33};
        vecs[9]  = '{DIV_OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF,
                     32'h8000_0000, 33};
        vecs[10] = '{DIV_OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};
        vecs[11] = '{DIV_OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33};
        vecs[12] = '{DIV_OP_DIV, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 33};
        vecs[13] = '{DIV_OP_REM, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                     32'hFFFF_FFFE, 33};
        vecs[14] = '{DIV_OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33};
        vecs[15] = '{DIV_OP_DIVU, 32'd3, 32'd5, 32'd0, 33};
        vecs[16] = '{DIV_OP_REMU, 32'd3, 32'd5, 32'd3, 33};
        vecs[17] = '{DIV_OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 1};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 0, W'(busy), W'(0));
        chk("rst_done", 0, W'(done), W'(0));
        chk("rst_stall", 0, W'(stall_req), W'(0));
        chk("rst_result", 0, result, W'(0));
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < NV; i++) run_op(i);

        // Flush mid-CALC, then a fresh op issued two cycles later.
        start = 1'b1; div_op = DIV_OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        #3;
        cyc();
        start = 1'b0;
        n_done = 0; done_cyc = -1; bad = 0; got = '0;
        for (int c = 1; c <= 48; c++) begin
            flush = (c == 10);
            start = (c == 12);
            if (c == 12) begin
                div_op = DIV_OP_DIVU; rs1 = 32'd1000; rs2 = 32'd9;
            end
            #3;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = result;
                end
            end
            if (c == 11) begin
                chk("flush_busy", 11, W'(busy), W'(0));
                chk("flush_stall", 11, W'(stall_req), W'(0));
            end
            if (c >= 11 && c <= 44 && result !== last_res) bad++;
            cyc();
        end
        flush = 1'b0; start = 1'b0;
        chk("flush_hold", 0, W'(bad), W'(0));
        chk("flush_done_count", 0, W'(n_done), W'(1));
        chk("flush_done_cycle", 0, W'(done_cyc), W'(45));
        chk("flush_new_result", 0, got, W'(111));
        last_res = 32'd111;

        // Start while busy is ignored.
        start = 1'b1; div_op = DIV_OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        #3;
        cyc();
        start = 1'b0;
        n_done = 0; done_cyc = -1; got = '0;
        for (int c = 1; c <= 40; c++) begin
            start = (c == 5);
            if (c == 5) begin
                div_op = DIV_OP_REMU; rs1 = 32'd50; rs2 = 32'd5;
            end
            #3;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    got = result;
                end
            end
            cyc();
        end
        start = 1'b0;
        chk("rebusy_done_count", 0, W'(n_done), W'(1));
        chk("rebusy_done_cycle", 0, W'(done_cyc), W'(33));
        chk("rebusy_result", 0, got, W'(14));
        last_res = 32'd14;

        // Flush and start together in IDLE.
        start = 1'b1; flush = 1'b1;
        div_op = DIV_OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        #3;
        chk("flushstart_stall", 0, W'(stall_req), W'(0));
        cyc();
        start = 1'b0; flush = 1'b0;
        #3;
        chk("flushstart_busy", 0, W'(busy), W'(0));
        chk("flushstart_done", 0, W'(done), W'(0));
        cyc();

        // Flush during FIN still shows done.
        start = 1'b1; div_op = DIV_OP_DIV; rs1 = 32'd5; rs2 = 32'd0;
        #3;
        cyc();
        start = 1'b0; flush = 1'b1;
        #3;
        chk("finflush_done", 0, W'(done), W'(1));
        chk("finflush_result", 0, result, W'(32'hFFFF_FFFF));
        cyc();
        flush = 1'b0;
        #3;
        chk("finflush_busy", 0, W'(busy), W'(0));
        chk("finflush_held", 0, result, W'(32'hFFFF_FFFF));
        cyc();

        // Reset dropped mid-CALC.
        start = 1'b1; div_op = DIV_OP_DIVU; rs1 = 32'd100; rs2 = 32'd7;
        #3;
        cyc();
        start = 1'b0;
        for (int c = 1; c < 15; c++) cyc();
        #3;
        chk("midrst_pre_busy", 0, W'(busy), W'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 0, W'(busy), W'(0));
        chk("midrst_done", 0, W'(done), W'(0));
        chk("midrst_stall", 0, W'(stall_req), W'(0));
        chk("midrst_result", 0, result, W'(0));
        cyc();
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            #3;
            if (busy !== 1'b0 || done !== 1'b0) bad++;
            cyc();
        end
        chk("midrst_idle", 0, W'(bad), W'(0));
        run_op(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
